// File: rtl/i_cache_refill_ctrl.sv
// Refill controller for the I-cache slice: on miss/flush it stalls fetch, streams a
// CACHE_SIZE-word window from memory into the slice, then reprograms base/bound.
module i_cache_refill_ctrl #(
  parameter int CACHE_SIZE  = 256,
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_address,
  input  logic        i_cache_miss,
  input  logic        flush,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        refill_enable,
  output logic [31:0] refill_address,
  output logic [31:0] refill_data,
  output logic [31:0] set_base_addr,
  output logic [31:0] set_bound_addr,
  output logic        base_addr_we,
  output logic        bound_addr_we,
  output logic [31:0] refill_count
);

  localparam int          CW        = $clog2(CACHE_SIZE) + 1;
  localparam logic [31:0] DEPTH     = 32'(CACHE_SIZE);
  localparam logic [31:0] MAX_OUT   = 32'(OUTSTANDING);
  localparam logic [31:0] WIN_BYTES = 32'(4 * CACHE_SIZE);
  localparam logic [31:0] WIN_MASK  = ~(WIN_BYTES - 32'd1);

  typedef enum logic [2:0] {IDLE, FILL, SET_BASE, SET_BOUND, SETTLE} state_t;

  state_t        state;
  logic [31:0]   win_base;
  logic [CW-1:0] req_cnt;
  logic [CW-1:0] rsp_cnt;
  logic [CW-1:0] inflight;
  logic [31:0]   req_ext;
  logic [31:0]   rsp_ext;
  logic [31:0]   inflight_ext;
  logic          in_fill;
  logic          req_fire;
  logic          rsp_take;

  assign inflight     = req_cnt - rsp_cnt;
  assign req_ext      = 32'(req_cnt);
  assign rsp_ext      = 32'(rsp_cnt);
  assign inflight_ext = 32'(inflight);
  assign in_fill      = (state == FILL);

  // Valid depends only on registered counters, so once raised it (and the address)
  // cannot drop before acceptance: inflight can only shrink while waiting.
  assign mem_req_valid = in_fill && (req_ext < DEPTH) && (inflight_ext < MAX_OUT);
  assign mem_req_addr  = in_fill ? (win_base + (req_ext << 2)) : 32'd0;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_take      = in_fill && mem_resp_valid && (inflight != '0);
  assign stall         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      win_base       <= '0;
      req_cnt        <= '0;
      rsp_cnt        <= '0;
      refill_enable  <= 1'b0;
      refill_address <= '0;
      refill_data    <= '0;
      set_base_addr  <= '0;
      set_bound_addr <= '0;
      base_addr_we   <= 1'b0;
      bound_addr_we  <= 1'b0;
      refill_count   <= '0;
    end else begin
      refill_enable <= 1'b0;
      base_addr_we  <= 1'b0;
      bound_addr_we <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cache_miss || flush) begin
            win_base <= fetch_address & WIN_MASK;
            req_cnt  <= '0;
            rsp_cnt  <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (req_fire) req_cnt <= req_cnt + CW'(1);
          if (rsp_take) begin
            refill_enable  <= 1'b1;
            refill_address <= rsp_ext;
            refill_data    <= mem_resp_data;
            rsp_cnt        <= rsp_cnt + CW'(1);
            // Last word: the base strobe lands alongside the final slice write.
            if (rsp_ext == DEPTH - 32'd1) begin
              state         <= SET_BASE;
              base_addr_we  <= 1'b1;
              set_base_addr <= win_base;
            end
          end
        end
        SET_BASE: begin
          bound_addr_we  <= 1'b1;
          set_bound_addr <= win_base + WIN_BYTES - 32'd1;
          state          <= SET_BOUND;
        end
        SET_BOUND: state <= SETTLE;
        SETTLE: begin
          if (refill_count != 32'hFFFF_FFFF) refill_count <= refill_count + 32'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i_cache_refill_ctrl.sv
// Bench for i_cache_refill_ctrl: two instances (OUTSTANDING 4 and 1) each fed by an
// in-order memory model with configurable ready pattern and response delay.
module tb_i_cache_refill_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [1:0][31:0]      fetch_address;
  logic [1:0]            i_cache_miss, flush, stall, mem_req_valid, mem_req_ready;
  logic [1:0]            mem_resp_valid, refill_enable, base_addr_we, bound_addr_we;
  logic [1:0][31:0]      mem_req_addr, mem_resp_data, refill_address, refill_data;
  logic [1:0][31:0]      set_base_addr, set_bound_addr, refill_count;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    i_cache_refill_ctrl #(.CACHE_SIZE(256), .OUTSTANDING(g == 0 ? 4 : 1)) u_dut (
      .clk(clk), .rst(rst), .fetch_address(fetch_address[g]),
      .i_cache_miss(i_cache_miss[g]), .flush(flush[g]), .stall(stall[g]),
      .mem_req_valid(mem_req_valid[g]), .mem_req_ready(mem_req_ready[g]),
      .mem_req_addr(mem_req_addr[g]), .mem_resp_valid(mem_resp_valid[g]),
      .mem_resp_data(mem_resp_data[g]), .refill_enable(refill_enable[g]),
      .refill_address(refill_address[g]), .refill_data(refill_data[g]),
      .set_base_addr(set_base_addr[g]), .set_bound_addr(set_bound_addr[g]),
      .base_addr_we(base_addr_we[g]), .bound_addr_we(bound_addr_we[g]),
      .refill_count(refill_count[g])
    );
  end

  // Memory model: data returned equals the requested byte address.
  int          ready_mode = 0;
  int          mem_delay = 1;
  int          mcyc = 0;
  logic [3:0]  ready_pat = 4'b1001;
  logic [31:0] q0_addr[$], q1_addr[$];
  int          q0_due[$], q1_due[$];

  always @(posedge clk) begin
    logic [31:0] a;
    int          d;
    mcyc = mcyc + 1;
    if (mem_req_valid[0] && mem_req_ready[0]) begin
      q0_addr.push_back(mem_req_addr[0]); q0_due.push_back(mcyc + mem_delay - 1);
    end
    if (mem_req_valid[1] && mem_req_ready[1]) begin
      q1_addr.push_back(mem_req_addr[1]); q1_due.push_back(mcyc + mem_delay - 1);
    end
    if (q0_due.size() > 0 && q0_due[0] <= mcyc) begin
      a = q0_addr.pop_front(); d = q0_due.pop_front();
      mem_resp_valid[0] <= 1'b1; mem_resp_data[0] <= a;
    end else mem_resp_valid[0] <= 1'b0;
    if (q1_due.size() > 0 && q1_due[0] <= mcyc) begin
      a = q1_addr.pop_front(); d = q1_due.pop_front();
      mem_resp_valid[1] <= 1'b1; mem_resp_data[1] <= a;
    end else mem_resp_valid[1] <= 1'b0;
    for (int g = 0; g < 2; g++) begin
      case (ready_mode)
        0:       mem_req_ready[g] <= 1'b1;
        1:       mem_req_ready[g] <= ready_pat[mcyc % 4];
        default: mem_req_ready[g] <= 1'($urandom_range(0, 1));
      endcase
    end
  end

  int          n_tests = 0, n_fail = 0;
  int          ref_cnt[2];
  int          obs_stall, obs_base_cyc, obs_bound_cyc, obs_last_wr, obs_both;
  int          obs_unstable, obs_max_infl;
  bit          obs_timeout;
  logic        obs_stall0, obs_stall1;
  logic [31:0] obs_base, obs_bound;
  logic [31:0] obs_req[$], obs_wa[$], obs_wd[$];

  function automatic logic [31:0] win_of(input logic [31:0] a);
    return a - (a % 32'd1024);
  endfunction

  // Presents a miss/flush at the current negedge and records everything the DUT does
  // until stall drops (or until abort_rsp responses were seen). Returns at a negedge.
  task automatic run_refill(input int g, input logic [31:0] fa, input bit m, input bit f,
                            input bit hold, input int abort_rsp);
    int acc = 0, rec = 0;
    bit done = 0, stuck = 0;
    logic [31:0] prev_addr = '0;
    obs_req.delete(); obs_wa.delete(); obs_wd.delete();
    obs_stall = 0; obs_base_cyc = -1; obs_bound_cyc = -1; obs_last_wr = -1;
    obs_both = 0; obs_unstable = 0; obs_max_infl = 0; obs_timeout = 0;
    fetch_address[g] = fa; i_cache_miss[g] = m; flush[g] = f;
    obs_stall0 = stall[g];
    for (int k = 1; k < 5000 && !done; k++) begin
      @(negedge clk);
      if (k == 1) obs_stall1 = stall[g];
      if (hold) fetch_address[g] = $urandom;
      else begin i_cache_miss[g] = 1'b0; flush[g] = 1'b0; end
      if (stuck && !(mem_req_valid[g] && mem_req_addr[g] == prev_addr)) obs_unstable++;
      if (mem_req_valid[g] && mem_req_ready[g]) begin
        if (acc - rec + 1 > obs_max_infl) obs_max_infl = acc - rec + 1;
        obs_req.push_back(mem_req_addr[g]);
        acc++;
      end
      stuck = mem_req_valid[g] && !mem_req_ready[g];
      prev_addr = mem_req_addr[g];
      if (mem_resp_valid[g]) rec++;
      if (refill_enable[g]) begin
        obs_wa.push_back(refill_address[g]); obs_wd.push_back(refill_data[g]); obs_last_wr = k;
      end
      if (base_addr_we[g]) begin obs_base_cyc = k; obs_base = set_base_addr[g]; end
      if (bound_addr_we[g]) begin obs_bound_cyc = k; obs_bound = set_bound_addr[g]; end
      if (base_addr_we[g] && bound_addr_we[g]) obs_both++;
      if (stall[g]) obs_stall++;
      else done = 1;
      if (abort_rsp > 0 && rec >= abort_rsp) done = 1;
    end
    if (!done) obs_timeout = 1;
    i_cache_miss[g] = 1'b0; flush[g] = 1'b0; fetch_address[g] = fa;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_tests++;
      if ({stall[g], mem_req_valid[g], mem_req_addr[g], refill_enable[g], refill_address[g],
           refill_data[g], set_base_addr[g], set_bound_addr[g], base_addr_we[g],
           bound_addr_we[g], refill_count[g]} !== '0) begin
        n_fail++; $display("FAIL reset_outputs dut%0d: stall=%b valid=%b cnt=%h want all zero",
                           g, stall[g], mem_req_valid[g], refill_count[g]);
      end
    end
    rst = 1'b0;
    ref_cnt[0] = 0; ref_cnt[1] = 0;
  endtask

  task automatic test_cold_miss();
    logic [31:0] base = 32'h800;
    int bad = 0;
    ready_mode = 0; mem_delay = 1;
    run_refill(0, 32'h0000_0A14, 1'b1, 1'b0, 1'b0, 0);
    ref_cnt[0]++;
    n_tests++; if (obs_timeout) begin n_fail++; $display("FAIL cold_timeout stall stuck high, want drop"); end
    n_tests++; if ({obs_stall0, obs_stall1} !== 2'b01) begin
      n_fail++; $display("FAIL cold_stall_edge got %b want 01", {obs_stall0, obs_stall1}); end
    n_tests++; if (obs_req.size() !== 256) begin
      n_fail++; $display("FAIL cold_req_count got %0d want 256", obs_req.size()); end
    foreach (obs_req[i]) if (obs_req[i] !== base + 32'(4 * i)) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL cold_req_addr got %0d bad want 0", bad); end
    n_tests++; if (obs_wa.size() !== 256) begin
      n_fail++; $display("FAIL cold_write_count got %0d want 256", obs_wa.size()); end
    bad = 0;
    foreach (obs_wa[i]) if (obs_wa[i] !== 32'(i) || obs_wd[i] !== base + 32'(4 * i)) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL cold_writes got %0d bad want 0", bad); end
    n_tests++; if ({obs_base, obs_bound} !== {base, 32'hBFF}) begin
      n_fail++; $display("FAIL cold_base_bound got %h/%h want %h/%h", obs_base, obs_bound, base, 32'hBFF); end
    n_tests++; if (obs_base_cyc !== obs_last_wr || obs_bound_cyc !== obs_base_cyc + 1 || obs_both !== 0) begin
      n_fail++; $display("FAIL cold_strobe_timing got base@%0d bound@%0d lastwr@%0d want base=lastwr, bound=base+1",
                         obs_base_cyc, obs_bound_cyc, obs_last_wr); end
    n_tests++; if (obs_stall !== 260) begin n_fail++; $display("FAIL cold_stall_len got %0d want 260", obs_stall); end
    n_tests++; if (refill_count[0] !== 32'(ref_cnt[0])) begin
      n_fail++; $display("FAIL cold_refill_count got %0d want %0d", refill_count[0], ref_cnt[0]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] fa = $urandom;
    logic [31:0] base = win_of(fa);
    int bad = 0;
    ready_mode = 1; mem_delay = 5;
    run_refill(0, fa, 1'b1, 1'b0, 1'b0, 0);
    ref_cnt[0]++;
    n_tests++; if (obs_max_infl > 4 || obs_max_infl < 1) begin
      n_fail++; $display("FAIL bp_inflight got max %0d want 1..4", obs_max_infl); end
    n_tests++; if (obs_unstable !== 0) begin
      n_fail++; $display("FAIL bp_addr_stable got %0d changes want 0", obs_unstable); end
    foreach (obs_req[i]) if (obs_req[i] !== base + 32'(4 * i)) bad++;
    n_tests++; if (bad !== 0 || obs_req.size() !== 256) begin
      n_fail++; $display("FAIL bp_requests got %0d reqs %0d bad want 256/0", obs_req.size(), bad); end
    bad = 0;
    foreach (obs_wa[i]) if (obs_wa[i] !== 32'(i) || obs_wd[i] !== base + 32'(4 * i)) bad++;
    n_tests++; if (bad !== 0 || obs_wa.size() !== 256) begin
      n_fail++; $display("FAIL bp_writes got %0d writes %0d bad want 256/0", obs_wa.size(), bad); end
    n_tests++; if ({obs_base, obs_bound, refill_count[0]} !== {base, base + 32'h3FF, 32'(ref_cnt[0])}) begin
      n_fail++; $display("FAIL bp_base_bound_cnt got %h/%h/%0d want %h/%h/%0d", obs_base, obs_bound,
                         refill_count[0], base, base + 32'h3FF, ref_cnt[0]); end
  endtask

  task automatic test_outstanding_one();
    logic [31:0] fa = 32'h0001_2340;
    int bad = 0;
    ready_mode = 0; mem_delay = 1;
    run_refill(1, fa, 1'b1, 1'b0, 1'b0, 0);
    ref_cnt[1]++;
    n_tests++; if (obs_max_infl !== 1) begin
      n_fail++; $display("FAIL os1_inflight got max %0d want 1", obs_max_infl); end
    foreach (obs_wa[i]) if (obs_wa[i] !== 32'(i) || obs_wd[i] !== win_of(fa) + 32'(4 * i)) bad++;
    n_tests++; if (bad !== 0 || obs_wa.size() !== 256) begin
      n_fail++; $display("FAIL os1_writes got %0d writes %0d bad want 256/0", obs_wa.size(), bad); end
    n_tests++; if (obs_stall !== 515) begin n_fail++; $display("FAIL os1_stall_len got %0d want 515", obs_stall); end
    n_tests++; if (refill_count[1] !== 32'(ref_cnt[1])) begin
      n_fail++; $display("FAIL os1_refill_count got %0d want %0d", refill_count[1], ref_cnt[1]); end
  endtask

  task automatic test_flush_hit();
    ready_mode = 0; mem_delay = 1;
    run_refill(0, 32'h0000_0404, 1'b0, 1'b1, 1'b0, 0);
    ref_cnt[0]++;
    n_tests++; if ({obs_stall0, obs_stall1} !== 2'b01 || obs_wa.size() !== 256) begin
      n_fail++; $display("FAIL flush_refill got stall %b writes %0d want 01/256", {obs_stall0, obs_stall1}, obs_wa.size()); end
    n_tests++; if ({obs_base, obs_bound} !== {32'h400, 32'h7FF}) begin
      n_fail++; $display("FAIL flush_base_bound got %h/%h want 00000400/000007ff", obs_base, obs_bound); end
    n_tests++; if (refill_count[0] !== 32'(ref_cnt[0])) begin
      n_fail++; $display("FAIL flush_refill_count got %0d want %0d", refill_count[0], ref_cnt[0]); end
  endtask

  task automatic test_top_of_space();
    ready_mode = 0; mem_delay = 1;
    run_refill(0, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 0);
    ref_cnt[0]++;
    n_tests++; if ({obs_base, obs_bound} !== {32'hFFFF_FC00, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL top_base_bound got %h/%h want fffffc00/ffffffff", obs_base, obs_bound); end
    n_tests++; if (obs_req.size() !== 256 || obs_req[obs_req.size() - 1] !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL top_last_req got %0d reqs last %h want 256/fffffffc", obs_req.size(),
                         obs_req.size() > 0 ? obs_req[obs_req.size() - 1] : 32'h0); end
  endtask

  task automatic test_back_to_back();
    ready_mode = 0; mem_delay = 1;
    run_refill(0, 32'h0000_5000, 1'b1, 1'b0, 1'b0, 0);
    ref_cnt[0]++;
    run_refill(0, 32'h0000_9ABC, 1'b1, 1'b0, 1'b0, 0);
    ref_cnt[0]++;
    n_tests++; if ({obs_stall0, obs_stall1} !== 2'b01 || obs_stall !== 260) begin
      n_fail++; $display("FAIL b2b_no_gap got stall %b len %0d want 01/260", {obs_stall0, obs_stall1}, obs_stall); end
    n_tests++; if (obs_base !== 32'h0000_9800) begin
      n_fail++; $display("FAIL b2b_base got %h want 00009800", obs_base); end
    n_tests++; if (refill_count[0] !== 32'(ref_cnt[0])) begin
      n_fail++; $display("FAIL b2b_refill_count got %0d want %0d", refill_count[0], ref_cnt[0]); end
  endtask

  task automatic test_reset_mid_fill();
    int noisy = 0, bad = 0;
    ready_mode = 0; mem_delay = 5;
    run_refill(0, 32'h0003_0000, 1'b1, 1'b0, 1'b0, 37);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({stall[0], mem_req_valid[0], mem_req_addr[0], refill_enable[0], refill_address[0],
         refill_data[0], set_base_addr[0], set_bound_addr[0], base_addr_we[0],
         bound_addr_we[0], refill_count[0]} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got stall=%b we=%b cnt=%0d want all zero",
                         stall[0], refill_enable[0], refill_count[0]);
    end
    ref_cnt[0] = 0; ref_cnt[1] = 0;
    repeat (12) begin
      @(negedge clk);
      if (refill_enable[0] || stall[0] || mem_req_valid[0]) noisy++;
    end
    n_tests++; if (noisy !== 0) begin n_fail++; $display("FAIL midreset_quiet got %0d active cycles want 0", noisy); end
    mem_delay = 1;
    run_refill(0, 32'h0003_0000, 1'b1, 1'b0, 1'b0, 0);
    ref_cnt[0]++;
    foreach (obs_wa[i]) if (obs_wa[i] !== 32'(i) || obs_wd[i] !== 32'h0003_0000 + 32'(4 * i)) bad++;
    n_tests++; if (bad !== 0 || obs_wa.size() !== 256) begin
      n_fail++; $display("FAIL midreset_restart got %0d writes %0d bad want 256/0", obs_wa.size(), bad); end
    n_tests++; if (refill_count[0] !== 32'(ref_cnt[0])) begin
      n_fail++; $display("FAIL midreset_refill_count got %0d want %0d", refill_count[0], ref_cnt[0]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int g = $urandom_range(0, 1);
      int sel = $urandom_range(1, 3);
      logic [31:0] fa = $urandom;
      logic [31:0] base = win_of(fa);
      int bad = 0;
      ready_mode = 2; mem_delay = $urandom_range(1, 4);
      run_refill(g, fa, sel[0], sel[1], 1'($urandom_range(0, 1)), 0);
      ref_cnt[g]++;
      foreach (obs_req[i]) if (obs_req[i] !== base + 32'(4 * i)) bad++;
      foreach (obs_wa[i]) if (obs_wa[i] !== 32'(i) || obs_wd[i] !== base + 32'(4 * i)) bad++;
      n_tests++; if (bad !== 0 || obs_req.size() !== 256 || obs_wa.size() !== 256 || obs_timeout) begin
        n_fail++; $display("FAIL rand%0d_traffic got %0d reqs %0d writes %0d bad want 256/256/0",
                           it, obs_req.size(), obs_wa.size(), bad); end
      n_tests++; if (obs_max_infl > (g == 0 ? 4 : 1) || obs_unstable !== 0) begin
        n_fail++; $display("FAIL rand%0d_flow got inflight %0d unstable %0d want <=%0d/0",
                           it, obs_max_infl, obs_unstable, g == 0 ? 4 : 1); end
      n_tests++; if ({obs_base, obs_bound} !== {base, base + 32'h3FF} || obs_bound_cyc !== obs_base_cyc + 1) begin
        n_fail++; $display("FAIL rand%0d_base_bound got %h/%h want %h/%h", it, obs_base, obs_bound,
                           base, base + 32'h3FF); end
      n_tests++; if (refill_count[g] !== 32'(ref_cnt[g])) begin
        n_fail++; $display("FAIL rand%0d_refill_count got %0d want %0d", it, refill_count[g], ref_cnt[g]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_cache_miss = '0;
    flush = '0;
    fetch_address = '0;
    test_reset();
    test_cold_miss();
    test_backpressure();
    test_outstanding_one();
    test_flush_hit();
    test_top_of_space();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
